// File: rtl/lut_ram.sv
`default_nettype none
// ============================================================================
// lut_ram : distributed RAM, one synchronous write port, one combinational read
//           port; per-entry valid bits give a one-cycle logical clear on reset.
// Revision: 1.0
// ============================================================================
module lut_ram #(
  parameter int LUT_WIDTH = 32,
  parameter int LUT_DEPTH = 256,
  localparam int AW = $clog2(LUT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [LUT_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [LUT_WIDTH-1:0] rd_data
);

  if ((LUT_DEPTH < 2) || ((LUT_DEPTH & (LUT_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("lut_ram: LUT_DEPTH must be a power of two and >= 2");
  end
  if (LUT_WIDTH < 1) begin : g_bad_width
    $error("lut_ram: LUT_WIDTH must be >= 1");
  end

  logic [LUT_WIDTH-1:0] mem [LUT_DEPTH];
  logic [LUT_DEPTH-1:0] valid;

  // Data array carries no reset so it maps onto LUT RAM; validity lives apart.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_addr] <= 1'b1;
    end
  end

  assign rd_data = valid[rd_addr] ? mem[rd_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_lut_ram.sv
`default_nettype none
// Self-checking bench for lut_ram: directed vector table, read-during-write
// sequence, and a randomized run against a reference model.
module tb_lut_ram;

  localparam int W = 32;
  localparam int D = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  lut_ram #(.LUT_WIDTH(W), .LUT_DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  logic [W-1:0] m_mem [D];
  logic         m_val [D];

  task automatic check(input string name, input int idx, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: rd_data=0x%08h expected 0x%08h", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Post-edge expectation for each vector: inputs held across one edge,
    // then rd_addr is presented and rd_data compared.
    vecs[0]  = '{1'b0, 1'b1, 8'd5,   32'hDEADBEEF, 8'd5,   32'hDEADBEEF};
    vecs[1]  = '{1'b0, 1'b0, 8'd0,   32'h0,        8'd6,   32'h00000000};
    vecs[2]  = '{1'b0, 1'b1, 8'd0,   32'h0000000A, 8'd0,   32'h0000000A};
    vecs[3]  = '{1'b0, 1'b1, 8'd255, 32'hFFFFFFFF, 8'd255, 32'hFFFFFFFF};
    vecs[4]  = '{1'b0, 1'b0, 8'd0,   32'h0,        8'd1,   32'h00000000};
    vecs[5]  = '{1'b0, 1'b0, 8'd0,   32'h0,        8'd254, 32'h00000000};
    vecs[6]  = '{1'b0, 1'b0, 8'd0,   32'h0,        8'd0,   32'h0000000A};
    vecs[7]  = '{1'b0, 1'b1, 8'd7,   32'h00000055, 8'd7,   32'h00000055};
    vecs[8]  = '{1'b0, 1'b0, 8'd7,   32'h12345678, 8'd7,   32'h00000055};
    vecs[9]  = '{1'b0, 1'b1, 8'd7,   32'h0000AAAA, 8'd7,   32'h0000AAAA};
    vecs[10] = '{1'b0, 1'b1, 8'd7,   32'h0000BBBB, 8'd7,   32'h0000BBBB};
    vecs[11] = '{1'b0, 1'b0, 8'd0,   32'h0,        8'd5,   32'hDEADBEEF};
    vecs[12] = '{1'b1, 1'b1, 8'd3,   32'hCAFEF00D, 8'd3,   32'h00000000};
    vecs[13] = '{1'b0, 1'b0, 8'd0,   32'h0,        8'd5,   32'h00000000};
    vecs[14] = '{1'b0, 1'b0, 8'd0,   32'h0,        8'd255, 32'h00000000};
    vecs[15] = '{1'b0, 1'b1, 8'd3,   32'hCAFEF00D, 8'd3,   32'hCAFEF00D};

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    step();
    rst = 1'b0;

    for (int i = 0; i < D; i++) begin
      rd_addr = AW'(i);
      #1;
      check("reset_sweep", i, rd_data, 32'h0);
    end

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; wr_en = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      step();
      rst = 1'b0; wr_en = 1'b0;
      rd_addr = vecs[i].rd_addr;
      #1;
      check("vector", i, rd_data, vecs[i].exp);
    end

    // Read-during-write to the same address: old value until the edge.
    wr_en = 1'b1; wr_addr = 8'd10; wr_data = 32'h11111111;
    step();
    wr_data = 32'h22222222; rd_addr = 8'd10;
    #1;
    check("rdw_before", 0, rd_data, 32'h11111111);
    step();
    wr_en = 1'b0;
    #1;
    check("rdw_after", 0, rd_data, 32'h22222222);

    // Randomized run against a reference model, starting from a clear.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int a = 0; a < D; a++) begin
      m_val[a] = 1'b0;
      m_mem[a] = '0;
    end
    for (int c = 0; c < 1000; c++) begin
      rst     = ($urandom_range(0, 49) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      wr_data = $urandom;
      rd_addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      #1;
      check("random", c, rd_data, m_val[rd_addr] ? m_mem[rd_addr] : 32'h0);
      @(posedge clk);
      if (rst) begin
        for (int a = 0; a < D; a++) m_val[a] = 1'b0;
      end else if (wr_en) begin
        m_mem[wr_addr] = wr_data;
        m_val[wr_addr] = 1'b1;
      end
      #1;
    end
    rst = 1'b0; wr_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lut_ram.md
Name: lut_ram

Overview:
- Single-clock distributed (LUT-based) RAM: one synchronous write port, one asynchronous (combinational) read port.
- Used as register-file/lookup storage inside the RISC-V core.
- Per-entry valid bits let a synchronous reset logically clear the whole array without iterating over the data storage.

Parameters:
- LUT_WIDTH, 32, data word width in bits (>=1).
- LUT_DEPTH, 256, number of words; must be a power of two, >=2. Elaboration error otherwise.
- Derived: AW = $clog2(LUT_DEPTH), the address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write enable, sampled on rising clk.
- wr_addr  input  AW  write address.
- wr_data  input  LUT_WIDTH  write data.
- rd_addr  input  AW  read address.
- rd_data  output  LUT_WIDTH  read data, combinational from rd_addr.
- Interface: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Storage:
  - mem[LUT_DEPTH] of LUT_WIDTH bits.
  - valid[LUT_DEPTH] of 1 bit each.
- Write:
  - On posedge clk with rst=0 and wr_en=1: mem[wr_addr] <= wr_data; valid[wr_addr] <= 1.
  - With wr_en=0: no state change.
- Read:
  - rd_data = valid[rd_addr] ? mem[rd_addr] : '0.
  - Purely combinational, zero-cycle latency; no output register.
- Read-during-write, same address, same cycle:
  - rd_data shows the pre-write contents until the clock edge (no bypass).
  - The new value is visible immediately after the edge.
- Reset:
  - On posedge clk with rst=1: all valid bits <= 0. mem contents may be left unchanged.
  - From the edge onward, rd_data = 0 for every address.
  - rd_data before the first reset is undefined (X permitted).
- Reset and write in the same cycle: reset wins; the write is dropped and the entry stays invalid.
- Reset mid-sequence: any write issued in a reset cycle is lost. Writes in the following cycle proceed normally.
- Addresses: full range 0..LUT_DEPTH-1 is legal; no wrap-around or out-of-range case (address width is exact).
- Back-to-back writes to the same address: last write wins, one word per cycle.
- No handshake, no stall; a write is accepted every cycle.

Test Plan:
- Reset then sweep reads: rst=1 one cycle, then rd_addr 0..255 -> rd_data=0x00000000 everywhere.
- Write/read: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; next cycle rd_addr=5 -> 0xDEADBEEF; rd_addr=6 -> 0.
- Read-during-write: mem[10]=0x11111111. Same cycle: wr_addr=10, wr_data=0x22222222, rd_addr=10 -> 0x11111111 before the edge, 0x22222222 after.
- Boundary addresses: write 0x0000000A to addr 0 and 0xFFFFFFFF to addr 255 -> each reads back exactly; addr 1 and addr 254 remain 0.
- Reset priority: rst=1 and wr_en=1 to addr 3 with 0xCAFEF00D in the same cycle -> addr 3 reads 0. A previously written addr 5 also reads 0.
- wr_en=0 with wr_addr=7, wr_data=0x12345678 -> addr 7 keeps its prior value. Finish with a randomized 1000-cycle run checked against a reference model.
